// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port word-addressed memory
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] i_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_rdata,
    output logic        d_rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

    slot_t       i_slot;
    slot_t       d_slot;
    logic [3:0]  streak;
    logic        i_elig;
    logic        d_elig;
    logic        grant_i;
    logic        grant_d;
    logic        d_misaligned;

    assign i_rsp_valid = (i_slot == FULL);
    assign d_rsp_valid = (d_slot == FULL);

    // Eligibility, priority with starvation guard, and the memory bus for the granted port
    always_comb begin
        i_elig           = !rst && i_req_valid && ((i_slot == EMPTY) || i_rsp_ready);
        d_elig           = !rst && d_req_valid && ((d_slot == EMPTY) || d_rsp_ready);
        grant_d          = d_elig && !(i_elig && (streak == MAX_STREAK));
        grant_i          = i_elig && !grant_d;
        i_req_ready      = grant_i;
        d_req_ready      = grant_d;
        d_misaligned     = (d_req_addr[1:0] != 2'b00);
        mem_address      = 32'h0;
        mem_write_data   = 32'h0;
        mem_write_enable = 1'b0;
        if (grant_d) begin
            mem_address      = d_req_addr;
            mem_write_data   = d_req_wdata;
            mem_write_enable = d_req_we && !d_misaligned;
        end else if (grant_i) begin
            mem_address = i_req_addr;
        end
    end

    // Fetch response slot: capture read data on accept, release on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            i_slot     <= EMPTY;
            i_rsp_data <= 32'h0;
        end else if (grant_i) begin
            i_slot     <= FULL;
            i_rsp_data <= mem_read_data;
        end else if ((i_slot == FULL) && i_rsp_ready) begin
            i_slot <= EMPTY;
        end
    end

    // Data response slot: writes return zero, misaligned accesses return an error
    always_ff @(posedge clk) begin
        if (rst) begin
            d_slot      <= EMPTY;
            d_rsp_rdata <= 32'h0;
            d_rsp_err   <= 1'b0;
        end else if (grant_d) begin
            d_slot      <= FULL;
            d_rsp_err   <= d_misaligned;
            d_rsp_rdata <= (d_misaligned || d_req_we) ? 32'h0 : mem_read_data;
        end else if ((d_slot == FULL) && d_rsp_ready) begin
            d_slot <= EMPTY;
        end
    end

    // Count data grants taken while fetch is waiting; any fetch grant resets the count
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= 4'h0;
        end else if (grant_i) begin
            streak <= 4'h0;
        end else if (grant_d && i_req_valid && (streak < MAX_STREAK)) begin
            streak <= streak + 4'h1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0, i_req_ready, i_rsp_valid, i_rsp_ready = 1'b1;
    logic [31:0] i_req_addr = 32'h0, i_rsp_data;
    logic        d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0, d_rsp_valid, d_rsp_ready = 1'b1, d_rsp_err;
    logic [31:0] d_req_addr = 32'h0, d_req_wdata = 32'h0, d_rsp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];

    logic [31:0] iq[$];
    logic [32:0] dq[$];
    byte         glog[$];
    int          streak = 0;
    bit          i_acc = 0, d_acc = 0, i_new = 0, d_new = 0, log_on = 0;
    int          i_gcnt = 0, d_gcnt = 0, we_cnt = 0;
    int          tests = 0, fails = 0;

    mem_port_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
        .d_rsp_err(d_rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory the arbiter drives: combinational read, write on the rising edge
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
    always @(negedge clk) if (mem_write_enable) we_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decides each cycle which port must be granted and what it must return
    always @(negedge clk) begin
        bit ie, de, gi, gd, mis;
        int idx;
        i_new = 0;
        d_new = 0;
        if (rst) begin
            check("rst_i_ready", {31'h0, i_req_ready}, 0);
            check("rst_d_ready", {31'h0, d_req_ready}, 0);
            check("rst_mem_we", {31'h0, mem_write_enable}, 0);
            iq.delete();
            dq.delete();
            streak = 0;
        end else begin
            ie = i_req_valid && (iq.size() == 0 || i_rsp_ready);
            de = d_req_valid && (dq.size() == 0 || d_rsp_ready);
            gd = de && !(ie && streak == MAX);
            gi = ie && !gd;
            check("i_req_ready", {31'h0, i_req_ready}, {31'h0, gi});
            check("d_req_ready", {31'h0, d_req_ready}, {31'h0, gd});
            if (gi) begin
                idx = int'(i_req_addr[7:2]);
                check("fetch_addr", mem_address, i_req_addr);
                check("fetch_we", {31'h0, mem_write_enable}, 0);
                iq.push_back(ref_mem[idx]);
                streak = 0;
                i_acc = 1; i_new = 1; i_gcnt++;
                if (log_on) glog.push_back("I");
            end else if (gd) begin
                idx = int'(d_req_addr[7:2]);
                mis = (d_req_addr[1:0] != 2'b00);
                check("data_addr", mem_address, d_req_addr);
                check("data_we", {31'h0, mem_write_enable}, {31'h0, d_req_we && !mis});
                if (mis) dq.push_back({1'b1, 32'h0});
                else if (d_req_we) begin
                    check("data_wdata", mem_write_data, d_req_wdata);
                    dq.push_back({1'b0, 32'h0});
                    ref_mem[idx] = d_req_wdata;
                end else dq.push_back({1'b0, ref_mem[idx]});
                if (i_req_valid && streak < MAX) streak++;
                d_acc = 1; d_new = 1; d_gcnt++;
                if (log_on) glog.push_back("D");
            end else begin
                check("idle_addr", mem_address, 0);
                check("idle_wdata", mem_write_data, 0);
                check("idle_we", {31'h0, mem_write_enable}, 0);
            end
        end
    end

    // Monitor: compares every presented response against the scoreboard queues
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (i_rsp_valid) begin
                if (iq.size() <= (i_new ? 1 : 0)) check("i_rsp_unexpected", 1, 0);
                else begin
                    check("i_rsp_data", i_rsp_data, iq[0]);
                    if (i_rsp_ready) void'(iq.pop_front());
                end
            end else if (iq.size() > (i_new ? 1 : 0)) check("i_rsp_missing", 0, 1);
            if (d_rsp_valid) begin
                if (dq.size() <= (d_new ? 1 : 0)) check("d_rsp_unexpected", 1, 0);
                else begin
                    check("d_rsp_rdata", d_rsp_rdata, dq[0][31:0]);
                    check("d_rsp_err", {31'h0, d_rsp_err}, {31'h0, dq[0][32]});
                    if (d_rsp_ready) void'(dq.pop_front());
                end
            end else if (dq.size() > (d_new ? 1 : 0)) check("d_rsp_missing", 0, 1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1; i_req_valid = 0; d_req_valid = 0;
        cyc();
        rst = 0; i_acc = 0; d_acc = 0;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        i_acc = 0; i_req_valid = 1; i_req_addr = a;
        for (int k = 0; k < 50 && !i_acc; k++) cyc();
        check("fetch_accept", {31'h0, i_acc}, 1);
        i_acc = 0; i_req_valid = 0;
    endtask

    task automatic do_data(input logic [31:0] a, input logic we, input logic [31:0] wd);
        d_acc = 0; d_req_valid = 1; d_req_addr = a; d_req_we = we; d_req_wdata = wd;
        for (int k = 0; k < 50 && !d_acc; k++) cyc();
        check("data_accept", {31'h0, d_acc}, 1);
        d_acc = 0; d_req_valid = 0;
    endtask

    task automatic new_fetch();
        i_req_addr = {24'h0, 8'($urandom_range(0, 255))};
    endtask

    task automatic new_data();
        d_req_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        if ($urandom_range(0, 4) == 0) d_req_addr[1:0] = 2'($urandom_range(1, 3));
        d_req_we    = 1'($urandom_range(0, 1));
        d_req_wdata = $urandom;
    endtask

    task automatic random_phase(input int n, input int pi, input int pd, input int pr);
        for (int c = 0; c < n; c++) begin
            cyc();
            if (!i_req_valid || i_acc) begin
                i_acc = 0; i_req_valid = ($urandom_range(0, 99) < pi); new_fetch();
            end
            if (!d_req_valid || d_acc) begin
                d_acc = 0; d_req_valid = ($urandom_range(0, 99) < pd); new_data();
            end
            i_rsp_ready = ($urandom_range(0, 99) < pr);
            d_rsp_ready = ($urandom_range(0, 99) < pr);
        end
    endtask

    // Both requesters stay valid; a new payload is presented only after acceptance
    task automatic streaming(input int n);
        for (int c = 0; c < n; c++) begin
            cyc();
            if (i_acc) begin i_acc = 0; new_fetch(); end
            if (d_acc) begin d_acc = 0; new_data(); end
        end
    endtask

    initial begin
        logic [31:0] saved;
        int dc;
        for (int k = 0; k < 64; k++) begin
            mem[k] = $urandom;
            ref_mem[k] = mem[k];
        end
        mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        // Reset held three cycles with both requesters valid
        rst = 1; i_req_valid = 1; d_req_valid = 1; i_req_addr = 32'h0; d_req_addr = 32'h0;
        repeat (3) cyc();
        check("rst_i_rsp_valid", {31'h0, i_rsp_valid}, 0);
        check("rst_d_rsp_valid", {31'h0, d_rsp_valid}, 0);
        check("rst_i_rsp_data", i_rsp_data, 0);
        check("rst_d_rsp_err", {31'h0, d_rsp_err}, 0);
        rst = 0; i_acc = 0; d_acc = 0;
        cyc();
        check("first_accept", {31'h0, d_acc}, 1);
        d_req_valid = 0; d_acc = 0;
        for (int k = 0; k < 20 && !i_acc; k++) cyc();
        i_req_valid = 0; i_acc = 0;
        cyc();

        // Single fetch with response backpressure and a second fetch waiting
        i_rsp_ready = 0;
        do_fetch(32'h10);
        i_req_valid = 1; i_req_addr = 32'h10;
        repeat (3) cyc();
        check("fetch_stall_held", {31'h0, i_rsp_valid}, 1);
        check("fetch_stall_data", i_rsp_data, 32'hDEADBEEF);
        i_rsp_ready = 1;
        do_fetch(32'h10);
        repeat (2) cyc();

        // Aligned write then read, misaligned write
        we_cnt = 0;
        do_data(32'h8, 1, 32'h12345678);
        repeat (2) cyc();
        check("write_pulse_count", we_cnt, 1);
        do_data(32'h8, 0, 32'h0);
        do_fetch(32'h8);
        repeat (2) cyc();
        saved = mem[2];
        we_cnt = 0;
        do_data(32'h9, 1, 32'hCAFEF00D);
        repeat (2) cyc();
        check("misaligned_no_we", we_cnt, 0);
        check("misaligned_mem", mem[2], saved);

        // Randomized traffic with mixed backpressure
        random_phase(1500, 60, 70, 70);
        random_phase(800, 90, 90, 100);
        i_req_valid = 0; d_req_valid = 0; i_rsp_ready = 1; d_rsp_ready = 1;
        repeat (3) cyc();

        // Fetch idle: data granted every cycle, then fairness pattern
        pulse_reset();
        i_acc = 0; d_acc = 0;
        new_data(); d_req_valid = 1;
        d_gcnt = 0;
        streaming(20);
        check("fetch_idle_data_every_cycle", d_gcnt, 20);
        glog.delete(); log_on = 1;
        new_fetch(); i_req_valid = 1;
        streaming(40);
        log_on = 0;
        dc = 0;
        foreach (glog[k]) begin
            if (glog[k] == "D") dc++;
            else begin
                check("starve_run_length", dc, MAX);
                dc = 0;
            end
        end
        check("starve_log_length", glog.size(), 40);

        // Backpressure isolation: stalled data slot must not block fetch
        pulse_reset();
        d_rsp_ready = 0; d_req_we = 0; d_req_addr = 32'h0; d_req_valid = 1;
        new_fetch(); i_req_valid = 1;
        streaming(1);
        i_gcnt = 0;
        streaming(20);
        check("isolation_fetch_every_cycle", i_gcnt, 20);
        rst = 1;
        cyc();
        check("midrst_i_rsp_valid", {31'h0, i_rsp_valid}, 0);
        check("midrst_d_rsp_valid", {31'h0, d_rsp_valid}, 0);
        rst = 0; i_req_valid = 0; d_req_valid = 0; d_rsp_ready = 1; i_acc = 0; d_acc = 0;

        random_phase(600, 50, 50, 80);
        i_req_valid = 0; d_req_valid = 0; i_rsp_ready = 1; d_rsp_ready = 1;
        repeat (4) cyc();
        check("drain_i_queue", iq.size(), 0);
        check("drain_d_queue", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port, word-addressed `memory` instance between the instruction-fetch port and the load/store data port of the core. It grants at most one access per cycle and drives the memory's address, write-data and write-enable lines. It captures the combinational read data into a per-port registered response slot, so each requester sees a valid/ready response one cycle after its request is accepted. Data accesses have priority; a streak counter guarantees instruction fetch cannot starve.

## Interface
- `MAX_DATA_STREAK`, 4: consecutive data grants allowed while fetch waits before fetch is forced; legal range 1–15.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req_valid` in 1; `i_req_ready` out 1; `i_req_addr` in 32: fetch request (read only).
- `i_rsp_valid` out 1; `i_rsp_ready` in 1; `i_rsp_data` out 32: fetch response.
- `d_req_valid` in 1; `d_req_ready` out 1; `d_req_addr` in 32; `d_req_we` in 1; `d_req_wdata` in 32: data request.
- `d_rsp_valid` out 1; `d_rsp_ready` in 1; `d_rsp_rdata` out 32; `d_rsp_err` out 1: data response.
- `mem_address` out 32; `mem_write_data` out 32; `mem_write_enable` out 1; `mem_read_data` in 32: memory bus, combinational read.

## Operation
- **Per-port response slot:** FSM states EMPTY and FULL; reset state is EMPTY.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on rsp handshake, unless a new accept happens in the same cycle, in which case it stays FULL with new data.
- **Eligibility:** a port is eligible when req_valid=1 and its slot is EMPTY, or FULL with rsp_ready=1 (draining this cycle).
- **Grant:**
  - Only data eligible → data.
  - Only fetch eligible → fetch.
  - Both eligible → data, unless streak == MAX_DATA_STREAK, in which case fetch.
  - The granted port's req_ready=1 and the other's is 0. req_ready is combinational from req_valid, slot state and rsp_ready.
- **Streak counter (4 bits):**
  - +1 on a data grant while i_req_valid=1, saturating at MAX_DATA_STREAK.
  - Cleared on any fetch grant.
  - Unchanged otherwise.
- **Memory bus in the grant cycle:** mem_address = granted addr.
  - Fetch grant: mem_write_enable = 0.
  - Data grant: mem_write_enable = d_req_we AND (addr[1:0] == 0); mem_write_data = d_req_wdata.
- **Memory bus with no grant:** mem_address = 0, mem_write_data = 0, mem_write_enable = 0.
- **Captured response:**
  - Fetch: i_rsp_data = mem_read_data. addr[1:0] is ignored, so the access is a word read.
  - Data read, aligned: rdata = mem_read_data, err = 0.
  - Data write, aligned: rdata = 0, err = 0.
  - Data access with addr[1:0] ≠ 0: no memory write, rdata = 0, err = 1.
- **Response stability:** rsp data and err are held stable while rsp_valid=1 and rsp_ready=0.

## Timing
- **Reset values:** all rsp_valid = 0, rsp data and err = 0, streak = 0, both slots EMPTY.
  - While rst=1: both req_ready = 0 and mem_write_enable = 0.
  - Reset mid-transaction discards pending responses; a request presented in the reset cycle is not accepted.
- **Latency:** request accepted at edge N (valid & ready) → rsp_valid = 1 from cycle N+1.
  - A write takes effect in memory at edge N.
- **Throughput:** one access per cycle total. With rsp_ready held at 1, a single port can be accepted every cycle.
- **Requester obligation:** req_valid and its payload are held stable until req_ready=1. Arbiter behaviour is undefined otherwise.
- **Backpressure isolation:** a port with a stalled response (FULL, rsp_ready=0) is never granted. The other port continues unaffected, with no head-of-line blocking.
- **Simultaneous drain+accept:** the old response handshakes and the new response appears the next cycle, so valid stays high continuously.
- **Read-during-write:** a data write's own response carries rdata = 0. A fetch of the same word in a later cycle sees the new value.

## Test plan
- **Reset:** hold rst 3 cycles with both req_valid = 1.
  - Required: all ready and rsp_valid = 0, mem_write_enable = 0 throughout.
  - First accept occurs in the first cycle after rst falls.
- **Single fetch, preload mem[4] = 0xDEADBEEF:** fetch addr 0x10 accepted at cycle N.
  - Required: i_rsp_valid = 1 at N+1 with data 0xDEADBEEF.
  - With i_rsp_ready = 0 for 3 cycles, the data is held and i_req_ready = 0.
- **Data write then read:** write 0x12345678 to 0x8, then read 0x8.
  - Write response: rdata = 0, err = 0.
  - Read response: 0x12345678.
  - mem_write_enable is high for exactly one cycle.
- **Misaligned write to 0x9:**
  - Required: mem_write_enable stays 0, d_rsp_err = 1, rdata = 0, mem[2] unchanged.
- **Starvation guard, MAX = 4:** both ports continuously valid, rsp_ready = 1.
  - Required grant sequence: D D D D I D D D D I…
  - With fetch idle, data is granted every cycle and the streak stays 0.
- **Backpressure isolation:** d_rsp_ready = 0 with the data slot FULL, fetch valid.
  - Required: fetch is granted every cycle.
  - Asserting rst mid-stream clears both rsp_valid on the next edge.
